// File: rtl/lcv_mul_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier.
// Holds the FSM state enum, default half width, stage/product widths and the partial-product shift table.
package lcv_mul_pkg;

    localparam int HALF_WIDTH_DEF = 16;

    localparam int MUL_OPND_W  = 2 * HALF_WIDTH_DEF;
    localparam int MUL_STAGE_W = 2 * (HALF_WIDTH_DEF + 1);
    localparam int MUL_PROD_W  = 4 * HALF_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mul_state_e;

    // Shift of each partial product in units of HALF_WIDTH, indexed by idx:
    // lo*lo -> 0, lo_a*hi_b -> 1, hi_a*lo_b -> 1, hi*hi -> 2.
    localparam logic [3:0][1:0] PP_SHIFT_MUL = {2'd2, 2'd1, 2'd1, 2'd0};

endpackage

// File: rtl/lcv_mul17_del1.sv
// Registered WxW signed multiply; maps onto one DSP slice.
// Latency: 1 cycle. Backpressure: none, free-running; datapath register has no reset.
module lcv_mul17_del1 #(
    parameter int W = 17
) (
    input  logic                  clk,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    always_ff @(posedge clk) begin
        p <= a * b;
    end

endmodule

// File: rtl/lcv_mul32_seq.sv
// Sequenced 32x32 multiplier: four 17x17 partial products accumulated into a 64-bit product.
// Latency: 5 cycles accept->out_valid; in_ready low until the result has been taken.
// Backpressure: result held stable in DONE until out_ready. LCV_MUL32_SEQ_MAC_EN adds the acc_in addend.
module lcv_mul32_seq
    import lcv_mul_pkg::*;
#(
    parameter int HALF_WIDTH = HALF_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*HALF_WIDTH-1:0] in_a,
    input  logic [2*HALF_WIDTH-1:0] in_b,
    input  logic                    in_signed,
`ifdef LCV_MUL32_SEQ_MAC_EN
    input  logic [4*HALF_WIDTH-1:0] acc_in,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*HALF_WIDTH-1:0] out_prod
);

    localparam int OPND_W  = 2 * HALF_WIDTH;
    localparam int SIDE_W  = HALF_WIDTH + 1;
    localparam int STAGE_W = 2 * SIDE_W;
    localparam int PROD_W  = 4 * HALF_WIDTH;

    mul_state_e          state_q, state_d;
    logic [1:0]          idx_q;
    logic [OPND_W-1:0]   a_q, b_q;
    logic                sgn_q;
    logic [PROD_W-1:0]   acc_q;
    logic                pend_vld_q;
    logic [1:0]          pend_idx_q;

    logic [SIDE_W-1:0]        lo_a, hi_a, lo_b, hi_b;
    logic signed [SIDE_W-1:0] op_x, op_y;
    logic signed [STAGE_W-1:0] stage_p;
    logic [PROD_W-1:0]        pp_ext, pp_shifted;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL: begin
                if (idx_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // lo halves are always unsigned; only the hi halves carry the operand sign
    assign lo_a = {1'b0, a_q[HALF_WIDTH-1:0]};
    assign lo_b = {1'b0, b_q[HALF_WIDTH-1:0]};
    assign hi_a = {sgn_q & a_q[OPND_W-1], a_q[OPND_W-1:HALF_WIDTH]};
    assign hi_b = {sgn_q & b_q[OPND_W-1], b_q[OPND_W-1:HALF_WIDTH]};

    assign op_x = idx_q[1] ? hi_a : lo_a;
    assign op_y = idx_q[0] ? hi_b : lo_b;

    lcv_mul17_del1 #(
        .W (SIDE_W)
    ) u_mul (
        .clk (clk),
        .a   (op_x),
        .b   (op_y),
        .p   (stage_p)
    );

    assign pp_ext = {{(PROD_W-STAGE_W){stage_p[STAGE_W-1]}}, stage_p};

    always_comb begin
        pp_shifted = pp_ext;
        case (PP_SHIFT_MUL[pend_idx_q])
            2'd0:    pp_shifted = pp_ext;
            2'd1:    pp_shifted = pp_ext << HALF_WIDTH;
            default: pp_shifted = pp_ext << (2 * HALF_WIDTH);
        endcase
    end

    // pend_* tags the stage register: it holds a real partial product only the cycle after MUL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            acc_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= (state_q == MUL);
            pend_idx_q <= idx_q;
            if (state_q == IDLE && in_valid) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sgn_q <= in_signed;
                idx_q <= 2'd0;
`ifdef LCV_MUL32_SEQ_MAC_EN
                acc_q <= acc_in;
`else
                acc_q <= '0;
`endif
            end else begin
                if (state_q == MUL) idx_q <= idx_q + 2'd1;
                if (pend_vld_q) acc_q <= acc_q + pp_shifted;
            end
        end
    end

    assign out_prod = acc_q;

endmodule

// File: tb/tb_lcv_mul32_seq.sv
// Scoreboard bench for lcv_mul32_seq; covers MAC cases when LCV_MUL32_SEQ_MAC_EN is defined.
module tb_lcv_mul32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        in_signed;
    logic [63:0] acc_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    lcv_mul32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
`ifdef LCV_MUL32_SEQ_MAC_EN
        .acc_in    (acc_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic [63:0] acc);
        logic [63:0] ea, eb, r;
        ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        r  = ea * eb;
`ifdef LCV_MUL32_SEQ_MAC_EN
        r  = r + acc;
`endif
        return r;
    endfunction

    // Waits for in_ready, presents one operand set for exactly the accept edge, pushes expectation.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] acc, input logic [63:0] exp, output bit ok);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = (n < 50);
        if (ok) begin
            in_a = a; in_b = b; in_signed = sgn; acc_in = acc; in_valid = 1'b1;
            exp_q.push_back(exp);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_signed = 1'b0; acc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_prod !== 64'h0) begin n_errors++; $display("FAIL reset_out_prod got %h want 0", out_prod); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        bit ok;
        int n = 0;
        bit busy_err = 1'b0;
        logic [63:0] e;
        send(32'd3, 32'd5, 1'b0, 64'd0, 64'd15, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL lat_accept timeout got in_ready %b want 1", in_ready); end
        while (out_valid !== 1'b1 && n < 50) begin
            if (in_ready !== 1'b0) busy_err = 1'b1;
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (n != 5) begin n_errors++; $display("FAIL lat_cycles got %0d want 5", n); end
        n_checks++;
        if (busy_err) begin n_errors++; $display("FAIL lat_in_ready_busy got 1 want 0"); end
        e = exp_q.pop_front();
        n_checks++;
        if (out_prod !== e) begin n_errors++; $display("FAIL lat_prod got %h want %h", out_prod, e); end
        take();
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL lat_idle_after got %b want 1", in_ready); end
    endtask

    task automatic test_extremes;
        logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic        ts[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] te[4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                               64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
        for (int i = 0; i < 4; i++) begin
            bit ok;
            int n;
            logic [63:0] e;
            send(ta[i], tb[i], ts[i], 64'd0, te[i], ok);
            wait_valid(n);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || n >= 50) begin
                n_errors++; $display("FAIL extreme_%0d timeout got %0d cycles want 5", i, n);
            end else if (out_prod !== e) begin
                n_errors++; $display("FAIL extreme_%0d got %h want %h", i, out_prod, e);
            end
            take();
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        bit held_err = 1'b0;
        logic [63:0] e;
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0), ok);
        wait_valid(n);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || n >= 50) begin n_errors++; $display("FAIL bp_timeout got %0d cycles want 5", n); end
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || out_prod !== e || in_ready !== 1'b0) held_err = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (held_err) begin n_errors++; $display("FAIL bp_hold got prod %h valid %b want %h 1", out_prod, out_valid, e); end
        n_checks++;
        if (out_prod !== e) begin n_errors++; $display("FAIL bp_prod got %h want %h", out_prod, e); end
        take();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_release got ready %b valid %b want 1 0", in_ready, out_valid);
        end
        send(32'd100, 32'd200, 1'b0, 64'd0, 64'd20000, ok);
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_next_accept got in_ready %b want 0", in_ready); end
        wait_valid(n);
        e = exp_q.pop_front();
        n_checks++;
        if (n >= 50 || out_prod !== e) begin n_errors++; $display("FAIL bp_next_prod got %h want %h", out_prod, e); end
        take();
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        bit spurious = 1'b0;
        logic [63:0] e;
        send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 64'd0, 64'd0, ok);
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0) spurious = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (spurious) begin n_errors++; $display("FAIL rstmid_spurious_valid got 1 want 0"); end
        send(32'd7, 32'd6, 1'b0, 64'd0, 64'd42, ok);
        wait_valid(n);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || n >= 50 || out_prod !== e) begin
            n_errors++; $display("FAIL rstmid_fresh got %h want %h", out_prod, e);
        end
        take();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit ok;
            int n;
            logic [31:0] a, b;
            logic        s;
            logic [63:0] acc, e;
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            acc = {$urandom, $urandom};
            send(a, b, s, acc, model(a, b, s, acc), ok);
            wait_valid(n);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || n >= 50 || out_prod !== e) begin
                n_errors++; $display("FAIL b2b_%0d got %h want %h (a %h b %h s %b)", i, out_prod, e, a, b, s);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

`ifdef LCV_MUL32_SEQ_MAC_EN
    task automatic test_mac;
        logic [31:0] ta[2] = '{32'd2, 32'hFFFF_FFFF};
        logic [31:0] tb[2] = '{32'd3, 32'hFFFF_FFFF};
        logic [63:0] tc[2] = '{64'd10, 64'h0000_0001_FFFF_FFFF};
        logic [63:0] te[2] = '{64'd16, 64'hFFFF_FFFF_0000_0000};
        for (int i = 0; i < 2; i++) begin
            bit ok;
            int n;
            logic [63:0] e;
            send(ta[i], tb[i], 1'b0, tc[i], te[i], ok);
            wait_valid(n);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok || n != 5 || out_prod !== e) begin
                n_errors++; $display("FAIL mac_%0d got %h in %0d cycles want %h in 5", i, out_prod, n, e);
            end
            take();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef LCV_MUL32_SEQ_MAC_EN
        test_mac();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
